mem_wb_stage: RTL and testbench

- Consumer side of the execute-stage outputs (PCSrcE, RegWriteE, MemtoRegE, MemWriteE, RdE, ALUResultE, WriteDataE).
- Holds the Memory pipeline register and drives the data-memory request/acknowledge bus for loads and stores.
- Back-pressures the upstream stages with stallM while a memory access is pending.
- Produces the Writeback register outputs (PCSrcW, RegWriteW, RdW, ResultW) for the register file and PC mux.

---
 rtl/mem_wb_stage.sv | 150 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// ============================================================================
// mem_wb_stage : Memory/Writeback pipeline registers with a req/ack data bus.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrcE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic [3:0]  RdE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        stallM,
  output logic        PCSrcW,
  output logic        RegWriteW,
  output logic [3:0]  RdW,
  output logic [31:0] ResultW,
  output logic        bus_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [7:0]  wait_cnt;
  logic        pcsrc_m;
  logic        regwrite_m;
  logic        memtoreg_m;
  logic        memwrite_m;
  logic [3:0]  rd_m;
  logic [31:0] alu_m;
  logic [31:0] wdata_m;
  logic        memop;
  logic        memop_e;
  logic        timeout;
  logic        load_m;

  assign memop   = memtoreg_m | memwrite_m;
  assign memop_e = MemtoRegE | MemWriteE;
  assign timeout = (wait_cnt == WAIT_LAST);
  assign load_m  = ~stallM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   state_next = memop_e ? S_ACCESS : S_IDLE;
      S_ACCESS: begin
        if (dmem_ack) begin
          state_next = memop_e ? S_ACCESS : S_IDLE;
        end else if (timeout) begin
          state_next = S_DONE;
        end else begin
          state_next = S_ACCESS;
        end
      end
      S_DONE:   state_next = memop_e ? S_ACCESS : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    dmem_req = memop & (state != S_DONE);
    stallM   = dmem_req & ~dmem_ack;
  end

  assign dmem_addr  = alu_m;
  assign dmem_wdata = wdata_m;
  assign dmem_we    = memwrite_m;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 8'd0;
    end else if (load_m) begin
      wait_cnt <= 8'd0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcsrc_m    <= 1'b0;
      regwrite_m <= 1'b0;
      memtoreg_m <= 1'b0;
      memwrite_m <= 1'b0;
      rd_m       <= 4'd0;
      alu_m      <= 32'd0;
      wdata_m    <= 32'd0;
    end else if (load_m) begin
      pcsrc_m    <= PCSrcE;
      regwrite_m <= RegWriteE;
      memtoreg_m <= MemtoRegE;
      memwrite_m <= MemWriteE;
      rd_m       <= RdE;
      alu_m      <= ALUResultE;
      wdata_m    <= WriteDataE;
    end
  end

  // A stalled M slot sends a bubble so the register file never sees a repeat write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PCSrcW    <= 1'b0;
      RegWriteW <= 1'b0;
      RdW       <= 4'd0;
      ResultW   <= 32'd0;
      bus_err   <= 1'b0;
    end else if (stallM) begin
      PCSrcW    <= 1'b0;
      RegWriteW <= 1'b0;
    end else if (state == S_DONE) begin
      PCSrcW    <= pcsrc_m;
      RegWriteW <= 1'b0;
      RdW       <= rd_m;
      ResultW   <= 32'd0;
      bus_err   <= 1'b1;
    end else begin
      PCSrcW    <= pcsrc_m;
      RegWriteW <= regwrite_m;
      RdW       <= rd_m;
      ResultW   <= memtoreg_m ? dmem_rdata : alu_m;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// tb_mem_wb_stage : self-checking bench for mem_wb_stage.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PCSrcE, RegWriteE, MemtoRegE, MemWriteE;
  logic [3:0]  RdE;
  logic [31:0] ALUResultE, WriteDataE;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        dmem_req, dmem_we, stallM;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        PCSrcW, RegWriteW, bus_err;
  logic [3:0]  RdW;
  logic [31:0] ResultW;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .RdE(RdE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .stallM(stallM), .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pcsrc, rw, mtr, mw;
    logic [3:0]  rd;
    logic [31:0] alu, wd;
  } instr_t;

  typedef struct {
    instr_t      e;
    logic        ack;
    logic [31:0] rdata;
    logic        x_req, x_stall, x_we;
    logic [31:0] x_addr;
    logic        x_rw;
    logic [3:0]  x_rd;
    logic [31:0] x_res;
  } vec_t;

  // Reference model: the instruction sitting in M, how many request cycles it
  // has waited, whether it has been given up on, and the architectural W view.
  instr_t      mdl_m;
  int          mdl_wait;
  bit          mdl_abort;
  logic        mdl_pcsrc_w, mdl_rw_w, mdl_err;
  logic [3:0]  mdl_rd_w;
  logic [31:0] mdl_res_w;

  function automatic instr_t mk(input logic pcsrc, input logic rw, input logic mtr,
                                input logic mw, input logic [3:0] rd,
                                input logic [31:0] alu, input logic [31:0] wd);
    instr_t t;
    t.pcsrc = pcsrc; t.rw = rw; t.mtr = mtr; t.mw = mw;
    t.rd = rd; t.alu = alu; t.wd = wd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mdl_m = mk(0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
    mdl_wait = 0; mdl_abort = 0;
    mdl_pcsrc_w = 0; mdl_rw_w = 0; mdl_err = 0;
    mdl_rd_w = 4'd0; mdl_res_w = 32'd0;
  endtask

  // Called just after a rising edge; applies one cycle of stimulus and
  // returns the mid-cycle view of the memory-side outputs.
  task automatic cycle(input instr_t e, input logic a, input logic [31:0] rdat,
                       output logic s_req, output logic s_stall,
                       output logic s_we, output logic [31:0] s_addr);
    logic exp_req, exp_stall;
    PCSrcE = e.pcsrc; RegWriteE = e.rw; MemtoRegE = e.mtr; MemWriteE = e.mw;
    RdE = e.rd; ALUResultE = e.alu; WriteDataE = e.wd;
    dmem_ack = a; dmem_rdata = rdat;
    #3;
    s_req = dmem_req; s_stall = stallM; s_we = dmem_we; s_addr = dmem_addr;
    exp_req   = (mdl_m.mtr | mdl_m.mw) & ~mdl_abort;
    exp_stall = exp_req & ~a;
    chk("model dmem_req", dmem_req, exp_req);
    chk("model stallM", stallM, exp_stall);
    if (exp_req) begin
      chk("model dmem_addr", dmem_addr, mdl_m.alu);
      chk("model dmem_we", dmem_we, mdl_m.mw);
      chk("model dmem_wdata", dmem_wdata, mdl_m.wd);
    end
    if (exp_stall) begin
      mdl_rw_w = 0; mdl_pcsrc_w = 0;
      mdl_wait++;
      if (mdl_wait == MAX_WAIT) mdl_abort = 1;
    end else begin
      mdl_pcsrc_w = mdl_m.pcsrc;
      mdl_rd_w    = mdl_m.rd;
      if (mdl_abort) begin
        mdl_rw_w = 0; mdl_res_w = 32'd0; mdl_err = 1;
      end else begin
        mdl_rw_w  = mdl_m.rw;
        mdl_res_w = mdl_m.mtr ? rdat : mdl_m.alu;
      end
      mdl_m = e; mdl_wait = 0; mdl_abort = 0;
    end
    @(posedge clk); #1;
    chk("model RegWriteW", RegWriteW, mdl_rw_w);
    chk("model PCSrcW", PCSrcW, mdl_pcsrc_w);
    chk("model RdW", RdW, mdl_rd_w);
    chk("model ResultW", ResultW, mdl_res_w);
    chk("model bus_err", bus_err, mdl_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t   tbl [13];
    instr_t nop, add1, ld1, ld2, st1, add2, st2, ld3, add3, ld4, ld5;
    logic   sr, ss, sw;
    logic [31:0] sa;

    nop  = mk(0, 0, 0, 0, 4'd0,  32'h0,        32'h0);
    add1 = mk(0, 1, 0, 0, 4'd3,  32'h10,       32'h0);
    ld1  = mk(0, 1, 1, 0, 4'd5,  32'h100,      32'h0);
    ld2  = mk(0, 1, 1, 0, 4'd6,  32'h104,      32'h0);
    st1  = mk(0, 0, 0, 1, 4'd7,  32'h200,      32'h55);
    add2 = mk(1, 1, 0, 0, 4'd9,  32'h20,       32'h0);
    st2  = mk(0, 1, 0, 1, 4'd4,  32'h300,      32'h1);
    ld3  = mk(0, 1, 1, 0, 4'd2,  32'h400,      32'h0);
    add3 = mk(0, 1, 0, 0, 4'd8,  32'h44,       32'h0);
    ld4  = mk(0, 1, 1, 0, 4'd11, 32'h500,      32'h0);
    ld5  = mk(0, 1, 1, 0, 4'd12, 32'h600,      32'h0);

    //          e     ack rdata          req stall we addr     rw rd    res
    tbl[0]  = '{add1, 0, 32'h0,        0, 0, 0, 32'h0,   0, 4'd0, 32'h0};
    tbl[1]  = '{ld1,  0, 32'h0,        0, 0, 0, 32'h0,   1, 4'd3, 32'h10};
    tbl[2]  = '{ld2,  1, 32'hDEADBEEF, 1, 0, 0, 32'h100, 1, 4'd5, 32'hDEADBEEF};
    tbl[3]  = '{nop,  1, 32'h12345678, 1, 0, 0, 32'h104, 1, 4'd6, 32'h12345678};
    tbl[4]  = '{st1,  0, 32'h0,        0, 0, 0, 32'h0,   0, 4'd0, 32'h0};
    tbl[5]  = '{add2, 0, 32'h0,        1, 1, 1, 32'h200, 0, 4'd0, 32'h0};
    tbl[6]  = '{add2, 0, 32'h0,        1, 1, 1, 32'h200, 0, 4'd0, 32'h0};
    tbl[7]  = '{add2, 1, 32'h0,        1, 0, 1, 32'h200, 0, 4'd7, 32'h200};
    tbl[8]  = '{nop,  1, 32'hFFFFFFFF, 0, 0, 0, 32'h0,   1, 4'd9, 32'h20};
    tbl[9]  = '{nop,  0, 32'h0,        0, 0, 0, 32'h0,   0, 4'd0, 32'h0};
    tbl[10] = '{st2,  0, 32'h0,        0, 0, 0, 32'h0,   0, 4'd0, 32'h0};
    tbl[11] = '{nop,  1, 32'hAAAA,     1, 0, 1, 32'h300, 1, 4'd4, 32'h300};
    tbl[12] = '{nop,  0, 32'h0,        0, 0, 0, 32'h0,   0, 4'd0, 32'h0};

    PCSrcE = 0; RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0;
    RdE = 0; ALUResultE = 0; WriteDataE = 0; dmem_ack = 0; dmem_rdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset dmem_req", dmem_req, 0);
    chk("reset stallM", stallM, 0);
    chk("reset RegWriteW", RegWriteW, 0);
    chk("reset PCSrcW", PCSrcW, 0);
    chk("reset RdW", RdW, 0);
    chk("reset ResultW", ResultW, 0);
    chk("reset bus_err", bus_err, 0);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].e, tbl[i].ack, tbl[i].rdata, sr, ss, sw, sa);
      chk($sformatf("vec%0d dmem_req", i), sr, tbl[i].x_req);
      chk($sformatf("vec%0d stallM", i), ss, tbl[i].x_stall);
      if (tbl[i].x_req) begin
        chk($sformatf("vec%0d dmem_we", i), sw, tbl[i].x_we);
        chk($sformatf("vec%0d dmem_addr", i), sa, tbl[i].x_addr);
      end
      chk($sformatf("vec%0d RegWriteW", i), RegWriteW, tbl[i].x_rw);
      chk($sformatf("vec%0d RdW", i), RdW, tbl[i].x_rd);
      chk($sformatf("vec%0d ResultW", i), ResultW, tbl[i].x_res);
    end

    // Timeout: MAX_WAIT request cycles, one DONE cycle, then normal traffic.
    cycle(ld3, 0, 32'h0, sr, ss, sw, sa);
    chk("abort pre req", sr, 0);
    for (int k = 0; k < MAX_WAIT; k++) begin
      cycle(add3, 0, 32'h0, sr, ss, sw, sa);
      chk("abort wait req", sr, 1);
      chk("abort wait stallM", ss, 1);
      chk("abort wait RegWriteW", RegWriteW, 0);
    end
    cycle(add3, 1, 32'h1111, sr, ss, sw, sa);
    chk("abort done req", sr, 0);
    chk("abort done stallM", ss, 0);
    chk("abort RegWriteW", RegWriteW, 0);
    chk("abort ResultW", ResultW, 0);
    chk("abort RdW", RdW, 4'd2);
    chk("abort bus_err", bus_err, 1);
    cycle(ld4, 0, 32'h0, sr, ss, sw, sa);
    chk("post abort add RegWriteW", RegWriteW, 1);
    chk("post abort add ResultW", ResultW, 32'h44);
    cycle(nop, 1, 32'hCAFEF00D, sr, ss, sw, sa);
    chk("post abort load stallM", ss, 0);
    chk("post abort load ResultW", ResultW, 32'hCAFEF00D);
    chk("post abort load RdW", RdW, 4'd11);
    chk("post abort bus_err sticky", bus_err, 1);

    // Reset pulse while a load is waiting.
    cycle(ld5, 0, 32'h0, sr, ss, sw, sa);
    cycle(nop, 0, 32'h0, sr, ss, sw, sa);
    cycle(nop, 0, 32'h0, sr, ss, sw, sa);
    chk("pending before reset req", dmem_req, 1);
    reset = 1'b0;
    #1;
    chk("midreset dmem_req", dmem_req, 0);
    chk("midreset stallM", stallM, 0);
    chk("midreset RegWriteW", RegWriteW, 0);
    chk("midreset PCSrcW", PCSrcW, 0);
    chk("midreset RdW", RdW, 0);
    chk("midreset ResultW", ResultW, 0);
    chk("midreset bus_err", bus_err, 0);
    model_reset();
    dmem_ack = 1'b1; dmem_rdata = 32'h77;
    @(posedge clk); #1;
    reset = 1'b1;
    cycle(nop, 1, 32'h77, sr, ss, sw, sa);
    chk("after reset req", sr, 0);
    chk("after reset RegWriteW", RegWriteW, 0);
    cycle(nop, 1, 32'h78, sr, ss, sw, sa);
    chk("after reset ResultW", ResultW, 0);

    // Randomized traffic checked against the model alone.
    for (int c = 0; c < 600; c++) begin
      instr_t e;
      int     kind;
      logic   a;
      kind = $urandom_range(0, 3);
      e = mk(0, 0, 0, 0, 4'($urandom), $urandom, $urandom);
      case (kind)
        1: begin e.rw = 1; e.pcsrc = 1'($urandom); end
        2: begin e.rw = 1; e.mtr = 1; end
        3: begin e.mw = 1; e.rw = 1'($urandom); end
        default: e.alu = $urandom;
      endcase
      if (((c / 100) % 2) == 0) a = ($urandom_range(0, 1) == 0);
      else                      a = ($urandom_range(0, 24) == 0);
      cycle(e, a, $urandom, sr, ss, sw, sa);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
